alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares the single combinational 32-bit ALU (5-bit ALUControl encoding, codes 0-29) between two requesters. Requester 0 is the pipeline EX-stage issue port; requester 1 is the SAD accumulation engine. The block arbitrates round-robin, registers operands into the ALU, and sequences multi-cycle multiply. It returns a registered result and Zero flag to the winning requester over a valid/ready handshake.

Parameters:
DATA_W, 32, operand/result width
OP_W, 5, ALU control width
MUL_CYCLES, 4, cycles the operands are held on the ALU for op 3 (mul), range 1..15
OP_LAST, 29, highest legal ALU control code

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this edge when valid&ready
req0_op  in  OP_W  ALU control code
req0_a  in  DATA_W  operand A
req0_b  in  DATA_W  operand B
req1_valid / req1_ready / req1_op / req1_a / req1_b  as requester 0
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 consumes result
rsp1_valid / rsp1_ready  as above for requester 1
rsp_result  out  DATA_W  registered result (shared)
rsp_zero  out  1  registered Zero flag
rsp_err  out  1  op code was > OP_LAST
alu_ctrl  out  OP_W  to ALU ALUControl
alu_a  out  DATA_W  to ALU A
alu_b  out  DATA_W  to ALU B
alu_result  in  DATA_W  from ALU
alu_zero  in  1  from ALU Zero
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n. All state clears immediately on assertion.
- Reset values: state=IDLE, all outputs 0, last_grant=1 (so requester 0 wins the first tie), mul counter 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready = 1 only for the granted requester, combinational on the valids.
  - Grant with one valid: that requester.
  - Grant with both valid: the requester != last_grant.
  - On the accept edge: latch op/a/b into alu_ctrl/alu_a/alu_b, record owner, update last_grant, go to EXEC.
- EXEC:
  - alu_* held stable from the registers.
  - Non-mul op: 1 cycle in EXEC.
  - op==3: MUL_CYCLES cycles, counted by a down-counter loaded at accept.
  - On the final EXEC edge: capture alu_result into rsp_result and alu_zero into rsp_zero, go to RESP.
- Illegal op (op > OP_LAST):
  - Accepted normally and spends 1 EXEC cycle.
  - Captures rsp_result=0, rsp_zero=1, rsp_err=1. The ALU output is ignored.
- RESP:
  - rspN_valid=1 for the owner only, held with result stable until rspN_ready.
  - On that edge: return to IDLE and clear rsp_valid.
  - The other requester's rsp_ready is ignored.
- Latency: accept edge E0 -> rsp_valid high after edge E1 (non-mul) or E_MUL_CYCLES (mul).
- Minimum issue interval: 3 cycles (no accept in RESP or EXEC). Both ready outputs are 0 outside IDLE.
- alu_* keep their last values in IDLE/RESP; they update only on accept.
- Requester dropping valid without handshake: no effect. Ops change only on accepted edges.
- Reset mid-EXEC or mid-RESP: the op is discarded, no response is issued, and last_grant returns to 1.

Optional Feature:
ALU_ARB_FIXED_PRIO_EN
- Defined: strict priority; requester 0 always wins when both are valid; last_grant is unused.
- Undefined: round-robin as above.

Decomposition:
- Package alu_arb_pkg:
  - ALU op constants OP_ADD=0, OP_SUB=2, OP_MUL=3, OP_SLT=28, OP_LAST=29.
  - FSM state enum {IDLE, EXEC, RESP}.
  - Owner type (1 bit).
- Sub-module rr_arb2: 2-way grant logic. Inputs are the valids, last_grant and the fixed-priority select; outputs are one-hot grant.

Test Plan:
- req0 add a=5 b=7 only -> req0_ready at once; rsp0_valid 2 edges later, result=12, zero=0, err=0.
- Both valid from reset: req0 sub 9-9, req1 add 1+1 -> req0 served first (result 0, zero=1), then req1 (result 2). Grant order across 4 tie rounds is 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN it is 0,0,0,0.
- req1 mul a=6 b=7 with MUL_CYCLES=4 -> alu_ctrl=3 held 4 cycles; rsp1_valid then result=42; req0 stays ready=0 throughout.
- Backpressure: rsp0_ready=0 for 5 cycles -> rsp0_valid and rsp_result stable, busy=1, no new accept; release -> IDLE next edge.
- Illegal op 31 -> rsp_err=1, result=0, zero=1.
- Reset asserted mid-mul (cycle 2 of 4) -> all outputs 0 asynchronously; after release, no stale rsp_valid; the next tie grants req0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU share arbiter: ALU op codes, FSM states, owner type.
package alu_arb_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_MUL  = 5'd3;
    localparam logic [4:0] OP_SLT  = 5'd28;
    localparam logic [4:0] OP_LAST = 5'd29;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic: round-robin on ties, or strict priority to requester 0
// when fixed_prio is set. Grant is one-hot, or zero when nobody is valid.
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic [1:0] grant
);

    // Pick a winner from the valids; on a tie favour whoever did not win last.
    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            if (fixed_prio || last_grant) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the EX-stage issue port (requester 0)
// and the SAD engine (requester 1). Registers operands into the ALU, holds
// them for MUL_CYCLES on a multiply, and returns a registered result/Zero
// flag to the owner over a valid/ready handshake.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: strict priority to requester 0
// instead of round-robin on ties.
module alu_share_arbiter #(
    parameter int DATA_W     = 32,
    parameter int OP_W       = 5,
    parameter int MUL_CYCLES = 4,
    parameter int OP_LAST    = 29
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [OP_W-1:0]   alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy
);

    import alu_arb_pkg::*;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    owner_t            owner;
    logic              last_grant;
    logic [3:0]        mul_cnt;
    logic [1:0]        grant;
    logic              accept;
    logic              rsp_take;
    logic              illegal_op;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .fixed_prio (FIXED_PRIO),
        .grant      (grant)
    );

    assign accept     = (state == IDLE) && (grant != 2'b00);
    assign req0_ready = (state == IDLE) && grant[0];
    assign req1_ready = (state == IDLE) && grant[1];
    assign rsp0_valid = (state == RESP) && (owner == 1'b0);
    assign rsp1_valid = (state == RESP) && (owner == 1'b1);
    assign rsp_take   = (owner == 1'b0) ? rsp0_ready : rsp1_ready;
    assign busy       = (state != IDLE);
    assign illegal_op = int'(alu_ctrl) > OP_LAST;
    assign sel_op     = grant[1] ? req1_op : req0_op;
    assign sel_a      = grant[1] ? req1_a  : req0_a;
    assign sel_b      = grant[1] ? req1_b  : req0_b;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept in IDLE, leave EXEC when the counter is spent, leave RESP on handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    if (mul_cnt == 4'd0) state_next = RESP;
            RESP:    if (rsp_take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch on accept, multiply hold counter, and result capture on the last EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            mul_cnt    <= 4'd0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (accept) begin
            alu_ctrl   <= sel_op;
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            owner      <= grant[1];
            last_grant <= grant[1];
            mul_cnt    <= (sel_op == OP_W'(OP_MUL)) ? MUL_LOAD : 4'd0;
        end else if (state == EXEC) begin
            if (mul_cnt != 4'd0) begin
                mul_cnt <= mul_cnt - 4'd1;
            end else if (illegal_op) begin
                rsp_result <= '0;
                rsp_zero   <= 1'b1;
                rsp_err    <= 1'b1;
            end else begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter. Provides a behavioural ALU on the
// alu_* port and checks grants, latency, results and handshakes against a
// transaction-level model of the arbiter.
module tb_alu_share_arbiter;

    localparam int DATA_W     = 32;
    localparam int OP_W       = 5;
    localparam int MUL_CYCLES = 4;
    localparam int OP_LAST    = 29;
    localparam int WAIT_MAX   = 50;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OP_W-1:0]   req0_op, req1_op;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero, rsp_err;
    logic [OP_W-1:0]   alu_ctrl;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic              alu_zero, busy;

    int checks = 0;
    int errors = 0;
    int model_last = 1;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .DATA_W(DATA_W), .OP_W(OP_W), .MUL_CYCLES(MUL_CYCLES), .OP_LAST(OP_LAST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    // Behavioural ALU: a few distinct operations are enough to tell ops apart.
    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a & b;
            5'd2:    return a - b;
            5'd3:    return a * b;
            5'd28:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
    assign alu_zero   = (alu_result == 32'd0);

    function automatic logic [31:0] exp_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (int'(op) > OP_LAST) return 32'd0;
        return alu_fn(op, a, b);
    endfunction

    function automatic int exp_latency(input logic [4:0] op);
        return (op == 5'd3) ? MUL_CYCLES : 1;
    endfunction

    // Tie goes to whoever did not win last (or always to 0 under fixed priority).
    function automatic int exp_winner(input bit v0, input bit v1);
        if (v0 && v1) return (FIXED || model_last == 1) ? 0 : 1;
        return v0 ? 0 : 1;
    endfunction

    function automatic logic [4:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return 5'd0;
            1:       return 5'd2;
            2:       return 5'd3;
            3:       return 5'd28;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    // Counts negedges until the owner's rsp_valid rises; bounded by WAIT_MAX.
    task automatic wait_rsp(input int who, output int cycles, output bit timed_out);
        cycles = 0;
        timed_out = 1'b0;
        while (!((who == 0) ? rsp0_valid : rsp1_valid)) begin
            if (cycles >= WAIT_MAX) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
             alu_ctrl, alu_a, alu_b, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got result=%h ctrl=%0d a=%h b=%h busy=%b rv=%b%b, expected all 0",
                     rsp_result, alu_ctrl, alu_a, alu_b, busy, rsp0_valid, rsp1_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got busy=%b rv=%b%b err=%b, expected 0", busy, rsp0_valid, rsp1_valid, rsp_err);
        end
    endtask

    task automatic test_single();
        int cyc;
        bit to;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 5'd0; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ready: got r0=%b r1=%b, expected r0=1 r1=0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        model_last = 0;
        wait_rsp(0, cyc, to);
        checks++;
        if (to || cyc != 1) begin
            errors++;
            $display("[TB] FAIL single_latency: got %0d cycles (timeout=%b), expected 1", cyc, to);
        end
        checks++;
        if (rsp_result !== 32'd12 || rsp_zero !== 1'b0 || rsp_err !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_result: got res=%0d z=%b e=%b rv1=%b, expected 12 0 0 0",
                     rsp_result, rsp_zero, rsp_err, rsp1_valid);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_release: got busy=%b rv0=%b, expected 0 0", busy, rsp0_valid);
        end
    endtask

    task automatic test_tie_order();
        int cyc, w, want;
        bit to;
        logic [31:0] er;
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            req0_valid = 1'b1; req0_op = 5'd2; req0_a = 32'd9; req0_b = 32'd9;
            req1_valid = 1'b1; req1_op = 5'd0; req1_a = 32'd1; req1_b = 32'd1;
            want = FIXED ? 0 : (r % 2);
            w = exp_winner(1'b1, 1'b1);
            #1;
            checks++;
            if (req0_ready !== (want == 0) || req1_ready !== (want == 1) || w != want) begin
                errors++;
                $display("[TB] FAIL tie_grant round %0d: got r0=%b r1=%b, expected winner %0d", r, req0_ready, req1_ready, want);
            end
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            model_last = want;
            wait_rsp(want, cyc, to);
            er = (want == 0) ? 32'd0 : 32'd2;
            checks++;
            if (to || rsp_result !== er || rsp_zero !== (want == 0) || rsp_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL tie_result round %0d: got res=%0d z=%b to=%b, expected %0d z=%b",
                         r, rsp_result, rsp_zero, to, er, (want == 0));
            end
            if (want == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
            @(negedge clk);
            rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        end
    endtask

    task automatic test_mul();
        int cyc;
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 5'd3; req1_a = 32'd6; req1_b = 32'd7;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mul_ready: got r0=%b r1=%b, expected r0=0 r1=1", req0_ready, req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 5'd0; req0_a = 32'd1; req0_b = 32'd1;
        model_last = 1;
        cyc = 0;
        while (!rsp1_valid && cyc < WAIT_MAX) begin
            checks++;
            if (alu_ctrl !== 5'd3 || alu_a !== 32'd6 || alu_b !== 32'd7 || req0_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mul_hold cycle %0d: got ctrl=%0d a=%0d b=%0d r0=%b, expected 3 6 7 0",
                         cyc, alu_ctrl, alu_a, alu_b, req0_ready);
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != MUL_CYCLES || rsp_result !== 32'd42 || rsp_err !== 1'b0 || req0_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mul_result: got %0d cycles res=%0d r0=%b, expected %0d cycles res=42 r0=0",
                     cyc, rsp_result, req0_ready, MUL_CYCLES);
        end
        rsp1_ready = 1'b1; req0_valid = 1'b0;
        @(negedge clk);
        rsp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc;
        bit to;
        logic [31:0] a, b, er;
        a = $urandom; b = $urandom;
        er = a + b;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 5'd0; req0_a = a; req0_b = b;
        @(negedge clk);
        req0_valid = 1'b0;
        model_last = 0;
        wait_rsp(0, cyc, to);
        req1_valid = 1'b1; req1_op = 5'd2; req1_a = 32'd3; req1_b = 32'd1;
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (to || rsp0_valid !== 1'b1 || rsp_result !== er || busy !== 1'b1 || req1_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL backpressure_hold cycle %0d: got rv0=%b res=%h busy=%b r1=%b, expected 1 %h 1 0",
                         s, rsp0_valid, rsp_result, busy, req1_ready, er);
            end
            @(negedge clk);
        end
        rsp0_ready = 1'b1; req1_valid = 1'b0;
        @(negedge clk);
        rsp0_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_release: got busy=%b rv0=%b, expected 0 0", busy, rsp0_valid);
        end
    endtask

    task automatic test_illegal();
        int cyc;
        bit to;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 5'd31; req0_a = $urandom | 32'd1; req0_b = 32'd0;
        @(negedge clk);
        req0_valid = 1'b0;
        model_last = 0;
        wait_rsp(0, cyc, to);
        checks++;
        if (to || cyc != 1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_op: got cyc=%0d res=%h z=%b e=%b, expected 1 0 1 1",
                     cyc, rsp_result, rsp_zero, rsp_err);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 5'd3; req1_a = 32'd11; req1_b = 32'd13;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
             alu_ctrl, alu_a, alu_b, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_mul: got ctrl=%0d a=%h b=%h busy=%b rv1=%b, expected all 0",
                     alu_ctrl, alu_a, alu_b, busy, rsp1_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_stale cycle %0d: got rv=%b%b busy=%b, expected 0", c, rsp0_valid, rsp1_valid, busy);
            end
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_tie: got r0=%b r1=%b, expected r0=1 r1=0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_random();
        int v, w, cyc, stall;
        bit to;
        logic [4:0] op0, op1, wop;
        logic [31:0] a0, b0, a1, b1, wa, wb, er;
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(1, 3);
            op0 = rand_op(); op1 = rand_op();
            a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            a1 = $urandom; b1 = $urandom_range(0, 100);
            @(negedge clk);
            req0_valid = v[0]; req0_op = op0; req0_a = a0; req0_b = b0;
            req1_valid = v[1]; req1_op = op1; req1_a = a1; req1_b = b1;
            w = exp_winner(v[0], v[1]);
            wop = (w == 0) ? op0 : op1;
            wa  = (w == 0) ? a0 : a1;
            wb  = (w == 0) ? b0 : b1;
            er  = exp_result(wop, wa, wb);
            #1;
            checks++;
            if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin
                errors++;
                $display("[TB] FAIL rand_grant %0d: got r0=%b r1=%b, expected winner %0d", i, req0_ready, req1_ready, w);
            end
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            model_last = w;
            wait_rsp(w, cyc, to);
            checks++;
            if (to || cyc != exp_latency(wop) || rsp_result !== er || rsp_zero !== (er == 32'd0 || int'(wop) > OP_LAST)
                || rsp_err !== (int'(wop) > OP_LAST) || ((w == 0) ? rsp1_valid : rsp0_valid) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rand_rsp %0d op=%0d: got cyc=%0d res=%h z=%b e=%b, expected cyc=%0d res=%h",
                         i, wop, cyc, rsp_result, rsp_zero, rsp_err, exp_latency(wop), er);
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                if (w == 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
                @(negedge clk);
                checks++;
                if (((w == 0) ? rsp0_valid : rsp1_valid) !== 1'b1 || rsp_result !== er || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rand_stall %0d: got res=%h busy=%b, expected res=%h busy=1", i, rsp_result, busy, er);
                end
            end
            rsp0_ready = (w == 0); rsp1_ready = (w == 1);
            @(negedge clk);
            rsp0_ready = 1'b0; rsp1_ready = 1'b0;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rand_release %0d: got busy=%b, expected 0", i, busy);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        test_reset();
        test_single();
        test_tie_order();
        test_mul();
        test_backpressure();
        test_illegal();
        test_reset_mid_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
